// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid entry, bubble/flush
// control zeroing and saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 93,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              bubble_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              m_valid_reg, m_valid_next;
    logic [CTRL_W-1:0] m_ctrl_reg,  m_ctrl_next;
    logic [DATA_W-1:0] m_data_reg,  m_data_next;
    logic              s_valid_reg, s_valid_next;
    logic [CTRL_W-1:0] s_ctrl_reg,  s_ctrl_next;
    logic [DATA_W-1:0] s_data_reg,  s_data_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;

    logic              accept;
    logic              drain;
    logic [CTRL_W-1:0] in_ctrl_eff;

    // With a skid entry the ready path is purely registered, breaking the
    // combinational out_ready -> in_ready chain across stages.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready_o = ~s_valid_reg;
        end else begin : g_ready_single
            assign in_ready_o = ~m_valid_reg | out_ready_i;
        end
    endgenerate

    assign accept      = in_valid_i & in_ready_o;
    assign drain       = m_valid_reg & out_ready_i;
    assign in_ctrl_eff = bubble_i ? '0 : in_ctrl_i;

    always_comb begin
        m_valid_next = m_valid_reg;
        m_ctrl_next  = m_ctrl_reg;
        m_data_next  = m_data_reg;
        s_valid_next = s_valid_reg;
        s_ctrl_next  = s_ctrl_reg;
        s_data_next  = s_data_reg;

        if (flush_i) begin
            m_valid_next = 1'b0;
            m_ctrl_next  = '0;
            s_valid_next = 1'b0;
            s_ctrl_next  = '0;
        end else if (SKID == 0) begin
            if (accept) begin
                m_valid_next = 1'b1;
                m_ctrl_next  = in_ctrl_eff;
                m_data_next  = in_data_i;
            end else if (drain) begin
                m_valid_next = 1'b0;
                m_ctrl_next  = '0;
            end
        end else begin
            if (~m_valid_reg | drain) begin
                // Main slot frees up: the older skid beat goes first to keep FIFO order.
                if (s_valid_reg) begin
                    m_valid_next = 1'b1;
                    m_ctrl_next  = s_ctrl_reg;
                    m_data_next  = s_data_reg;
                    if (accept) begin
                        s_ctrl_next = in_ctrl_eff;
                        s_data_next = in_data_i;
                    end else begin
                        s_valid_next = 1'b0;
                        s_ctrl_next  = '0;
                    end
                end else if (accept) begin
                    m_valid_next = 1'b1;
                    m_ctrl_next  = in_ctrl_eff;
                    m_data_next  = in_data_i;
                end else begin
                    m_valid_next = 1'b0;
                    m_ctrl_next  = '0;
                end
            end else if (accept) begin
                s_valid_next = 1'b1;
                s_ctrl_next  = in_ctrl_eff;
                s_data_next  = in_data_i;
            end
        end
    end

    always_comb begin
        stall_cnt_next  = stall_cnt_reg;
        bubble_cnt_next = bubble_cnt_reg;
        if (cnt_clr_i) begin
            stall_cnt_next  = '0;
            bubble_cnt_next = '0;
        end else begin
            if (m_valid_reg && !out_ready_i && !flush_i && (stall_cnt_reg != '1))
                stall_cnt_next = stall_cnt_reg + CNT_W'(1);
            if (accept && bubble_i && (bubble_cnt_reg != '1))
                bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg    <= 1'b0;
            m_ctrl_reg     <= '0;
            m_data_reg     <= '0;
            s_valid_reg    <= 1'b0;
            s_ctrl_reg     <= '0;
            s_data_reg     <= '0;
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            m_valid_reg    <= m_valid_next;
            m_ctrl_reg     <= m_ctrl_next;
            m_data_reg     <= m_data_next;
            s_valid_reg    <= s_valid_next;
            s_ctrl_reg     <= s_ctrl_next;
            s_data_reg     <= s_data_next;
            stall_cnt_reg  <= stall_cnt_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign out_valid_o  = m_valid_reg;
    assign out_ctrl_o   = m_ctrl_reg;
    assign out_data_o   = m_data_reg;
    assign stall_cnt_o  = stall_cnt_reg;
    assign bubble_cnt_o = bubble_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance a is single-entry with 4-bit counters, instance b
// has the skid entry with 16-bit counters.
module tb_pipe_stage_reg;

    localparam int CW = 11;
    localparam int DW = 93;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_bubble, a_flush, a_out_valid, a_out_ready, a_cnt_clr;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [3:0]    a_stall, a_bub;

    logic          b_in_valid, b_in_ready, b_bubble, b_flush, b_out_valid, b_out_ready, b_cnt_clr;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_stall, b_bub;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_n(rst_n),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_ctrl_i(a_in_ctrl), .in_data_i(a_in_data),
        .bubble_i(a_bubble), .flush_i(a_flush),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_ctrl_o(a_out_ctrl), .out_data_o(a_out_data),
        .cnt_clr_i(a_cnt_clr), .stall_cnt_o(a_stall), .bubble_cnt_o(a_bub)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_n(rst_n),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_ctrl_i(b_in_ctrl), .in_data_i(b_in_data),
        .bubble_i(b_bubble), .flush_i(b_flush),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_ctrl_o(b_out_ctrl), .out_data_o(b_out_data),
        .cnt_clr_i(b_cnt_clr), .stall_cnt_o(b_stall), .bubble_cnt_o(b_bub)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_in_valid = 0; a_in_ctrl = '0; a_in_data = '0; a_bubble = 0; a_flush = 0;
        a_out_ready = 0; a_cnt_clr = 0;
        b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_bubble = 0; b_flush = 0;
        b_out_ready = 0; b_cnt_clr = 0;

        #2;
        chk("a_rst_valid", a_out_valid, 0);
        chk("a_rst_ctrl", a_out_ctrl, 0);
        chk("a_rst_data", a_out_data, 0);
        chk("a_rst_ready", a_in_ready, 1);
        chk("a_rst_cnts", {a_stall, a_bub}, 0);
        chk("b_rst_valid", b_out_valid, 0);
        chk("b_rst_ready", b_in_ready, 1);
        @(negedge clk);
        rst_n = 1;

        // ---- single entry: first beat, stall, drain ----
        tick();
        a_in_valid = 1; a_in_ctrl = 11'h5A3; a_in_data = 93'h1_2345; a_out_ready = 1;
        tick();
        chk("a_first_valid", a_out_valid, 1);
        chk("a_first_ctrl", a_out_ctrl, 11'h5A3);
        chk("a_first_data", a_out_data, 93'h1_2345);
        a_in_valid = 0; a_out_ready = 0;
        #1;
        chk("a_stall_ready", a_in_ready, 0);
        tick(); tick(); tick();
        chk("a_stall_cnt3", a_stall, 3);
        chk("a_stall_ctrl", a_out_ctrl, 11'h5A3);
        chk("a_stall_data", a_out_data, 93'h1_2345);
        a_out_ready = 1;
        #1;
        chk("a_ready_comb", a_in_ready, 1);
        tick();
        chk("a_drain_valid", a_out_valid, 0);
        chk("a_drain_ctrl", a_out_ctrl, 0);
        chk("a_drain_data_hold", a_out_data, 93'h1_2345);
        chk("a_drain_stall", a_stall, 3);

        // ---- bubble ----
        a_in_valid = 1; a_bubble = 1; a_in_ctrl = 11'h7FF; a_in_data = 93'hABCD;
        tick();
        chk("a_bub_valid", a_out_valid, 1);
        chk("a_bub_ctrl", a_out_ctrl, 0);
        chk("a_bub_data", a_out_data, 93'hABCD);
        chk("a_bub_cnt", a_bub, 1);
        a_in_valid = 0;
        tick();
        chk("a_bub_noacc_cnt", a_bub, 1);
        chk("a_bub_noacc_valid", a_out_valid, 0);
        a_bubble = 0;

        // ---- saturation and clear ----
        a_in_valid = 1; a_in_ctrl = 11'h001; a_in_data = 93'h1; a_out_ready = 0;
        tick();
        a_in_valid = 0;
        repeat (20) tick();
        chk("a_stall_sat", a_stall, 15);
        a_cnt_clr = 1;
        tick();
        chk("a_clr_stall", a_stall, 0);
        chk("a_clr_bub", a_bub, 0);
        a_cnt_clr = 0;
        tick();
        chk("a_after_clr_stall", a_stall, 1);

        // ---- flush ----
        a_flush = 1;
        tick();
        chk("a_flush_valid", a_out_valid, 0);
        chk("a_flush_ctrl", a_out_ctrl, 0);
        chk("a_flush_data_hold", a_out_data, 93'h1);
        chk("a_flush_no_stall", a_stall, 1);
        a_in_valid = 1; a_bubble = 1; a_in_ctrl = 11'h123; a_in_data = 93'hDEAD;
        tick();
        chk("a_flushbub_valid", a_out_valid, 0);
        chk("a_flushbub_data", a_out_data, 93'h1);
        chk("a_flushbub_cnt", a_bub, 1);
        a_flush = 0; a_in_valid = 0; a_bubble = 0;

        // ---- skid: A,B then C ----
        b_in_valid = 1; b_in_ctrl = 11'h0A1; b_in_data = 93'hA1;
        tick();
        chk("b_A_ctrl", b_out_ctrl, 11'h0A1);
        chk("b_A_ready", b_in_ready, 1);
        b_in_ctrl = 11'h0B2; b_in_data = 93'hB2;
        tick();
        chk("b_B_ctrl_m", b_out_ctrl, 11'h0A1);
        chk("b_B_ready", b_in_ready, 0);
        chk("b_B_stall", b_stall, 1);
        b_in_ctrl = 11'h0C3; b_in_data = 93'hC3; b_out_ready = 1;
        #1;
        chk("b_ready_registered", b_in_ready, 0);
        tick();
        chk("b_out_B", b_out_data, 93'hB2);
        chk("b_out_B_ctrl", b_out_ctrl, 11'h0B2);
        chk("b_ready_back", b_in_ready, 1);
        tick();
        chk("b_out_C", b_out_data, 93'hC3);
        chk("b_out_C_valid", b_out_valid, 1);
        b_in_valid = 0;
        tick();
        chk("b_empty", b_out_valid, 0);

        // ---- skid: flush with M and S full ----
        b_out_ready = 0; b_in_valid = 1; b_in_ctrl = 11'h0D1; b_in_data = 93'hD1;
        tick();
        b_in_ctrl = 11'h0D2; b_in_data = 93'hD2;
        tick();
        chk("b_full_ready", b_in_ready, 0);
        b_in_ctrl = 11'h0DD; b_in_data = 93'hDD; b_flush = 1;
        tick();
        chk("b_flush_valid", b_out_valid, 0);
        chk("b_flush_ctrl", b_out_ctrl, 0);
        chk("b_flush_ready", b_in_ready, 1);
        b_flush = 0; b_in_valid = 0; b_out_ready = 1;
        tick();
        chk("b_D_absent", b_out_valid, 0);
        chk("b_flush_data_hold", b_out_data, 93'hD1);

        // ---- asynchronous reset between edges ----
        a_in_valid = 1; a_in_ctrl = 11'h055; a_in_data = 93'h55; a_out_ready = 0;
        b_in_valid = 1; b_in_ctrl = 11'h066; b_in_data = 93'h66; b_out_ready = 0;
        tick();
        chk("a_pre_rst_valid", a_out_valid, 1);
        chk("b_pre_rst_valid", b_out_valid, 1);
        a_in_valid = 0; b_in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        chk("a_arst_valid", a_out_valid, 0);
        chk("a_arst_data", a_out_data, 0);
        chk("a_arst_ready", a_in_ready, 1);
        chk("a_arst_cnt", a_bub, 0);
        chk("b_arst_valid", b_out_valid, 0);
        chk("b_arst_ctrl", b_out_ctrl, 0);
        chk("b_arst_stall", b_stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
